alu: RTL
========

// Module: alu
// PURPOSE
//  Execution end of the RS->ALU dispatch interface and source of the ALU result broadcast.
//  Accepts one integer/branch/jump op per cycle from the reservation station.
//  Computes the value and resolves the branch.
//  Registers the result one cycle later onto the broadcast bus (RS, LSB, ROB).
//  Fully pipelined: no backpressure, throughput one op per cycle.
// PARAMETERS
//  DATA_W     32  operand/result width (`DATA_WID)
//  ADDR_W     32  pc width (`ADDR_WID)
//  ROB_POS_W   4  ROB index width (`ROB_POS_WID)
// PORTS
//  clk              in   1       clock; all state updates on posedge
//  rst              in   1       synchronous active-high reset
//  rdy              in   1       global enable; low = hold all state
//  rollback         in   1       mispredict flush
//  alu_en           in   1       op valid this cycle
//  alu_opcode       in   7       RV32I opcode
//  alu_func3        in   3       funct3
//  alu_func7        in   1       instr[30] (SUB/SRA select)
//  alu_val1         in   DATA_W  rs1 value
//  alu_val2         in   DATA_W  rs2 value
//  alu_imm          in   DATA_W  sign-extended immediate
//  alu_pc           in   ADDR_W  instruction pc
//  alu_rob_pos      in   ROB_POS_W  destination ROB entry
//  result           out  1       broadcast valid (registered)
//  result_rob_pos   out  ROB_POS_W  ROB entry of result
//  result_val       out  DATA_W  rd value
//  result_jump      out  1       control transfer taken
//  result_pc        out  ADDR_W  resolved next pc
// BEHAVIOUR
//  Reset: rst high at posedge -> result, result_rob_pos, result_val, result_jump, result_pc all 0.
//  Priority at a posedge: rst > rollback > !rdy (hold) > normal update.
//  rollback: result<=0; the op on alu_en that cycle is discarded.
//   Other output regs are don't-care.
//  !rdy: every output reg holds its value, including result=1.
//   The broadcast is consumed once rdy returns.
//  Normal: result<=alu_en, so latency is exactly 1 cycle.
//   When alu_en=0 the data regs may hold stale values.
//  Operand B: alu_imm for OP-IMM (0010011), else alu_val2.
//  Arithmetic ops, by func3, for OP (0110011) and OP-IMM:
//   000 ADD; SUB only for OP with func7=1.
//   001 SLL; 010 SLT signed; 011 SLTU unsigned.
//   100 XOR; 110 OR; 111 AND.
//   101 SRL, or SRA when func7=1 (OP and OP-IMM).
//  Shift amount = B[4:0]. ADDI ignores func7.
//  LUI (0110111): val=imm. AUIPC (0010111): val=pc+imm.
//  JAL (1101111): val=pc+4, jump=1, next pc=pc+imm.
//  JALR (1100111): val=pc+4, jump=1, next pc=(val1+imm)&~1.
//  BRANCH (1100011): val=0. Condition by func3:
//   000 EQ, 001 NE, 100 LT signed, 101 GE signed, 110 LTU, 111 GEU.
//   010/011 are never taken.
//   Taken: jump=1, next pc=pc+imm. Not taken: jump=0, next pc=pc+4.
//  Non-jump ops: jump=0, next pc=pc+4.
//  Unknown opcode: still broadcast so the ROB cannot hang; val=0, jump=0, next pc=pc+4.
//  All adds wrap modulo 2^32; no overflow or exception flags.
//  Back-to-back alu_en: each op appears on the outputs exactly one cycle after issue.
//   No merging, no drops.
// STRUCTURE
//  Shared cons.v: width macros, opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
//   OPC_BR, OPC_OPI, OPC_OP), func3 encodings.
//  One combinational always block computes next val/jump/pc.
//  One sequential block holds the output register stage.
//  No sub-module needed; optional alu_br_cmp (branch comparator) if reused by the LSB.
// TESTING
//  ADD/SUB: OP, func3=000.
//   func7=0, val1=5, val2=7 -> next cycle result=1, val=12.
//   func7=1 -> val=0xFFFFFFFE.
//  Shifts: SRAI, val1=0x80000000, imm=0x404 (func7=1, shamt=4) -> val=0xF8000000.
//   SRLI with the same operands -> val=0x08000000.
//  Branches: BLT, val1=0xFFFFFFFF, val2=1, pc=0x100, imm=0x20 -> jump=1, result_pc=0x120.
//   BLTU with the same operands -> jump=0, result_pc=0x104.
//  JALR: pc=0x40, val1=0x1003, imm=0 -> val=0x44, jump=1, result_pc=0x1002.
//  Pipelining: alu_en for 3 consecutive cycles with rob_pos 1,2,3
//   -> result high for 3 cycles, rob_pos 1,2,3 in order.
//  Control: rollback with alu_en=1 -> result=0 next cycle.
//   rdy=0 for 2 cycles while result=1 -> all outputs unchanged.
//   rst mid-stream -> all outputs 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, RV32I opcode encodings and funct3 encodings used by
// the ALU and its branch comparator.
package alu_pkg;

    localparam int DATA_WID    = 32;
    localparam int ADDR_WID    = 32;
    localparam int ROB_POS_WID = 4;

    // Major opcodes the ALU executes; anything else is broadcast as a no-op.
    typedef enum logic [6:0] {
        OPC_LUI   = 7'b0110111,
        OPC_AUIPC = 7'b0010111,
        OPC_JAL   = 7'b1101111,
        OPC_JALR  = 7'b1100111,
        OPC_BR    = 7'b1100011,
        OPC_OPI   = 7'b0010011,
        OPC_OP    = 7'b0110011
    } opcode_e;

    // Arithmetic funct3 (OP / OP-IMM)
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

endpackage

// File: rtl/alu_br_cmp.sv
// alu_br_cmp: branch condition evaluator, kept separate so the load/store
// side can reuse it.
//   a_i, b_i   : rs1 / rs2 values
//   func3_i    : branch funct3
//   taken_o    : condition holds (010/011 never taken)
module alu_br_cmp
    import alu_pkg::*;
#(
    parameter int W = DATA_WID
) (
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic [2:0]   func3_i,
    output logic         taken_o
);

    always_comb begin
        taken_o = 1'b0;
        case (func3_i)
            F3_BEQ:  taken_o = (a_i == b_i);
            F3_BNE:  taken_o = (a_i != b_i);
            F3_BLT:  taken_o = ($signed(a_i) <  $signed(b_i));
            F3_BGE:  taken_o = ($signed(a_i) >= $signed(b_i));
            F3_BLTU: taken_o = (a_i <  b_i);
            F3_BGEU: taken_o = (a_i >= b_i);
            default: taken_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/alu.sv
// alu: execution end of the RS->ALU dispatch path. Computes one integer /
// branch / jump op per cycle and registers the result onto the broadcast bus
// one cycle later. No backpressure.
//   clk, rst        : clock, synchronous active-high reset
//   rdy             : global enable, low holds every output register
//   rollback        : mispredict flush, kills the op issued this cycle
//   alu_*           : issued op (valid, opcode, funct3, instr[30], operands,
//                     immediate, pc, destination ROB entry)
//   result*         : registered broadcast (valid, ROB entry, rd value,
//                     control transfer taken, resolved next pc)
module alu
    import alu_pkg::*;
#(
    parameter int DATA_W    = DATA_WID,
    parameter int ADDR_W    = ADDR_WID,
    parameter int ROB_POS_W = ROB_POS_WID
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rdy,
    input  logic                 rollback,
    input  logic                 alu_en,
    input  logic [6:0]           alu_opcode,
    input  logic [2:0]           alu_func3,
    input  logic                 alu_func7,
    input  logic [DATA_W-1:0]    alu_val1,
    input  logic [DATA_W-1:0]    alu_val2,
    input  logic [DATA_W-1:0]    alu_imm,
    input  logic [ADDR_W-1:0]    alu_pc,
    input  logic [ROB_POS_W-1:0] alu_rob_pos,
    output logic                 result,
    output logic [ROB_POS_W-1:0] result_rob_pos,
    output logic [DATA_W-1:0]    result_val,
    output logic                 result_jump,
    output logic [ADDR_W-1:0]    result_pc
);

    logic [DATA_W-1:0]    opb;
    logic [4:0]           shamt;
    logic [ADDR_W-1:0]    pc_seq;
    logic [ADDR_W-1:0]    pc_tgt;
    logic [DATA_W-1:0]    jalr_sum;
    logic                 br_taken;

    logic [DATA_W-1:0]    val_d;
    logic                 jump_d;
    logic [ADDR_W-1:0]    pc_d;

    logic                 result_q;
    logic [ROB_POS_W-1:0] rob_pos_q;
    logic [DATA_W-1:0]    val_q;
    logic                 jump_q;
    logic [ADDR_W-1:0]    pc_q;

    alu_br_cmp #(.W(DATA_W)) u_br_cmp (
        .a_i     (alu_val1),
        .b_i     (alu_val2),
        .func3_i (alu_func3),
        .taken_o (br_taken)
    );

    always_comb begin
        opb      = (alu_opcode == OPC_OPI) ? alu_imm : alu_val2;
        shamt    = opb[4:0];
        pc_seq   = alu_pc + ADDR_W'(4);
        pc_tgt   = alu_pc + ADDR_W'(alu_imm);
        jalr_sum = alu_val1 + alu_imm;

        // Unknown opcodes fall through with val=0, no jump, sequential pc.
        val_d  = '0;
        jump_d = 1'b0;
        pc_d   = pc_seq;

        case (alu_opcode)
            OPC_OP, OPC_OPI: begin
                case (alu_func3)
                    // Immediate forms carry no SUB: ADDI ignores instr[30].
                    F3_ADD:  val_d = (alu_opcode == OPC_OP && alu_func7) ?
                                     alu_val1 - opb : alu_val1 + opb;
                    F3_SLL:  val_d = alu_val1 << shamt;
                    F3_SLT:  val_d = DATA_W'($signed(alu_val1) < $signed(opb));
                    F3_SLTU: val_d = DATA_W'(alu_val1 < opb);
                    F3_XOR:  val_d = alu_val1 ^ opb;
                    F3_SR:   val_d = alu_func7 ?
                                     $unsigned($signed(alu_val1) >>> shamt) :
                                     alu_val1 >> shamt;
                    F3_OR:   val_d = alu_val1 | opb;
                    F3_AND:  val_d = alu_val1 & opb;
                    default: val_d = '0;
                endcase
            end
            OPC_LUI:   val_d = alu_imm;
            OPC_AUIPC: val_d = DATA_W'(pc_tgt);
            OPC_JAL: begin
                val_d  = DATA_W'(pc_seq);
                jump_d = 1'b1;
                pc_d   = pc_tgt;
            end
            OPC_JALR: begin
                val_d  = DATA_W'(pc_seq);
                jump_d = 1'b1;
                pc_d   = ADDR_W'({jalr_sum[DATA_W-1:1], 1'b0});
            end
            OPC_BR: begin
                jump_d = br_taken;
                pc_d   = br_taken ? pc_tgt : pc_seq;
            end
            default: ;
        endcase
    end

    // Data regs update whenever rdy is high; they are only meaningful while
    // result_q is set, so idle cycles may leave stale values.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q  <= 1'b0;
            rob_pos_q <= '0;
            val_q     <= '0;
            jump_q    <= 1'b0;
            pc_q      <= '0;
        end else if (rollback) begin
            result_q  <= 1'b0;
        end else if (rdy) begin
            result_q  <= alu_en;
            rob_pos_q <= alu_rob_pos;
            val_q     <= val_d;
            jump_q    <= jump_d;
            pc_q      <= pc_d;
        end
    end

    assign result         = result_q;
    assign result_rob_pos = rob_pos_q;
    assign result_val     = val_q;
    assign result_jump    = jump_q;
    assign result_pc      = pc_q;

endmodule
